// File: rtl/dac_wave_gen.sv
// Dual-channel DAC sample generator: rate divider ticks two phase accumulators,
// each shaped into a 12-bit waveform and offered to the DAC driver via valid/ready.
module dac_wave_gen #(
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic [PHASE_W-1:0] freq_a,
  input  logic [PHASE_W-1:0] freq_b,
  input  logic [1:0]         wave_sel_a,
  input  logic [1:0]         wave_sel_b,
  input  logic               dac_ready,
  input  logic               clr_ovr,
  output logic [11:0]        DATA_A,
  output logic [11:0]        DATA_B,
  output logic               data_valid,
  output logic               overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_a_q, phase_a_d, phase_b_q, phase_b_d;
  logic [11:0]        data_a_q, data_a_d, data_b_q, data_b_d;
  logic               valid_q, valid_d, ovr_q, ovr_d;
  logic               tick, xfer, ovr_ev;
  logic [PHASE_W-1:0] next_a, next_b;

  // Waveform shaping from the top 12 bits of the (already advanced) phase.
  function automatic logic [11:0] wave(input logic [1:0] sel, input logic [PHASE_W-1:0] ph);
    logic [11:0] tri_v;
    tri_v = {ph[PHASE_W-2 -: 11], 1'b0};
    case (sel)
      2'd0:    wave = ph[PHASE_W-1 -: 12];
      2'd1:    wave = ph[PHASE_W-1] ? ~tri_v : tri_v;
      2'd2:    wave = ph[PHASE_W-1] ? 12'hFFF : 12'h000;
      default: wave = 12'h800;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          cnt_d   = '0;
          state_d = valid_q ? DRAIN : IDLE;
        end else if (phase_clr) begin
          cnt_d = '0;
        end else if (cnt_q == rate_div) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DRAIN: begin
        cnt_d = '0;
        if (!valid_q || dac_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign next_a = phase_a_q + freq_a;
  assign next_b = phase_b_q + freq_b;
  assign xfer   = valid_q & dac_ready;
  assign ovr_ev = tick & valid_q & ~dac_ready;

  always_comb begin
    phase_a_d = phase_a_q;
    phase_b_d = phase_b_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    valid_d   = valid_q;
    if (phase_clr) begin
      phase_a_d = '0;
      phase_b_d = '0;
    end else if (tick) begin
      phase_a_d = next_a;
      phase_b_d = next_b;
    end
    // A tick always reloads the pair; a same-cycle transfer simply keeps valid high.
    if (tick) begin
      data_a_d = wave(wave_sel_a, next_a);
      data_b_d = wave(wave_sel_b, next_b);
      valid_d  = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    ovr_d = ovr_ev ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_a_q <= '0;
      phase_b_q <= '0;
      data_a_q  <= 12'h000;
      data_b_q  <= 12'h000;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_a_q <= phase_a_d;
      phase_b_q <= phase_b_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign DATA_A     = data_a_q;
  assign DATA_B     = data_b_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen: a waveform table plus hand-sequenced handshake corners.
module tb_dac_wave_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, phase_clr, dac_ready, clr_ovr;
  logic [15:0] rate_div, freq_a, freq_b;
  logic [1:0]  wave_sel_a, wave_sel_b;
  logic [11:0] DATA_A, DATA_B;
  logic        data_valid, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_wave_gen #(.PHASE_W(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .phase_clr(phase_clr),
    .rate_div(rate_div), .freq_a(freq_a), .freq_b(freq_b),
    .wave_sel_a(wave_sel_a), .wave_sel_b(wave_sel_b),
    .dac_ready(dac_ready), .clr_ovr(clr_ovr),
    .DATA_A(DATA_A), .DATA_B(DATA_B), .data_valid(data_valid), .overrun(overrun)
  );

  typedef struct {
    logic [1:0]  wsel_b;
    logic [11:0] exp_a;
    logic [11:0] exp_b;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance at least one clock, then until data_valid is seen (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!data_valid && cyc < 50);
    checks++;
    if (!data_valid) begin
      errors++;
      $display("FAIL wait_valid: got timeout after %0d cycles expected data_valid", cyc);
    end
  endtask

  initial begin
    int cyc;
    // channel A sawtooth (freq 0x1000) runs alongside channel B wave sequence (freq 0x2000)
    tbl[0]  = '{2'd1, 12'h100, 12'h400};
    tbl[1]  = '{2'd1, 12'h200, 12'h800};
    tbl[2]  = '{2'd1, 12'h300, 12'hC00};
    tbl[3]  = '{2'd1, 12'h400, 12'hFFF};
    tbl[4]  = '{2'd1, 12'h500, 12'hBFF};
    tbl[5]  = '{2'd1, 12'h600, 12'h7FF};
    tbl[6]  = '{2'd1, 12'h700, 12'h3FF};
    tbl[7]  = '{2'd1, 12'h800, 12'h000};
    tbl[8]  = '{2'd2, 12'h900, 12'h000};
    tbl[9]  = '{2'd2, 12'hA00, 12'h000};
    tbl[10] = '{2'd2, 12'hB00, 12'h000};
    tbl[11] = '{2'd2, 12'hC00, 12'hFFF};
    tbl[12] = '{2'd2, 12'hD00, 12'hFFF};
    tbl[13] = '{2'd3, 12'hE00, 12'h800};
    tbl[14] = '{2'd3, 12'hF00, 12'h800};
    tbl[15] = '{2'd3, 12'h000, 12'h800};

    rst = 1'b0; enable = 1'b0; phase_clr = 1'b0; dac_ready = 1'b1; clr_ovr = 1'b0;
    rate_div = 16'd4; freq_a = 16'h1000; freq_b = 16'h2000;
    wave_sel_a = 2'd0; wave_sel_b = 2'd1;
    repeat (2) @(negedge clk);
    check("reset DATA_A", DATA_A, 12'h000);
    check("reset DATA_B", DATA_B, 12'h000);
    check("reset valid", data_valid, 1'b0);
    check("reset overrun", overrun, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wave_sel_b = tbl[i].wsel_b;
      wait_valid(cyc);
      check($sformatf("tbl[%0d] DATA_A", i), DATA_A, tbl[i].exp_a);
      check($sformatf("tbl[%0d] DATA_B", i), DATA_B, tbl[i].exp_b);
      check($sformatf("tbl[%0d] overrun", i), overrun, 1'b0);
      if (i > 0) check($sformatf("tbl[%0d] period", i), cyc, 5);
    end

    // Overrun: let the last pair transfer, then stop accepting.
    rate_div = 16'd2; wave_sel_b = 2'd3;
    @(negedge clk);
    check("ovr pre valid", data_valid, 1'b0);
    dac_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("ovr tick1 valid", data_valid, 1'b1);
    check("ovr tick1 overrun", overrun, 1'b0);
    check("ovr tick1 DATA_A", DATA_A, 12'h100);
    repeat (3) @(negedge clk);
    check("ovr tick2 overrun", overrun, 1'b1);
    check("ovr tick2 DATA_A", DATA_A, 12'h200);
    dac_ready = 1'b1; clr_ovr = 1'b1;
    @(negedge clk);
    check("clr valid", data_valid, 1'b0);
    check("clr overrun", overrun, 1'b0);
    dac_ready = 1'b0; clr_ovr = 1'b0;
    repeat (2) @(negedge clk);
    check("tick3 valid", data_valid, 1'b1);
    check("tick3 DATA_A", DATA_A, 12'h300);
    repeat (2) @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    check("clr vs event overrun", overrun, 1'b1);
    check("clr vs event DATA_A", DATA_A, 12'h400);
    @(negedge clk);
    clr_ovr = 1'b0;
    check("clr idle overrun", overrun, 1'b0);
    check("clr idle valid", data_valid, 1'b1);

    // Transfer coinciding with a tick.
    @(negedge clk);
    dac_ready = 1'b1;
    @(negedge clk);
    dac_ready = 1'b0;
    check("sim valid", data_valid, 1'b1);
    check("sim overrun", overrun, 1'b0);
    check("sim DATA_A", DATA_A, 12'h500);

    // Enable drop with a pending pair: drain, no ticks.
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("drain valid", data_valid, 1'b1);
    check("drain DATA_A", DATA_A, 12'h500);
    dac_ready = 1'b1;
    @(negedge clk);
    dac_ready = 1'b0;
    check("drain accept valid", data_valid, 1'b0);
    enable = 1'b1;
    wave_sel_b = 2'd0;
    wait_valid(cyc);
    check("restart DATA_A", DATA_A, 12'h600);
    check("restart latency", cyc, 4);

    // phase_clr on a tick cycle.
    dac_ready = 1'b1;
    repeat (2) @(negedge clk);
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    check("pclr valid", data_valid, 1'b0);
    check("pclr DATA_A held", DATA_A, 12'h600);
    wait_valid(cyc);
    check("pclr next DATA_A", DATA_A, 12'h100);
    check("pclr next DATA_B", DATA_B, 12'h200);
    check("pclr next period", cyc, 3);

    // Asynchronous reset mid-run with a pending pair.
    dac_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset valid", data_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async DATA_A", DATA_A, 12'h000);
    check("async DATA_B", DATA_B, 12'h000);
    check("async valid", data_valid, 1'b0);
    check("async overrun", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
